acc_serial_alu: RTL

ACC_SERIAL_ALU -- requirements
Module: acc_serial_alu

---
 rtl/acc_serial_alu.sv | 91 +++++++++
 1 files changed

// File: rtl/acc_serial_alu.sv
// acc_serial_alu: bit-serial accumulator ALU (LDA/ADD/SUB/NEG/SHR), one result bit per clock, LSB first
module acc_serial_alu #(
  parameter int LINE_LENGTH = 40,
  parameter int INSTR_FUNCTION_BITS = 6,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_LDA = 6'b100000,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_ADD = 6'b101100,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SUB = 6'b100110,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_NEG = 6'b110110,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SHR = 6'b111110
) (
  input  logic                           w_CLK,
  input  logic                           w_RST_N,
  input  logic                           w_START,
  input  logic [0:INSTR_FUNCTION_BITS-1] b_FST,
  input  logic [0:LINE_LENGTH-1]         b_A_DATA_IN,
  input  logic                           w_ACEG,
  output logic [0:LINE_LENGTH-1]         b_ACC,
  output logic                           w_ACC_NEG,
  output logic                           w_BUSY,
  output logic                           w_DONE,
  output logic                           w_OVF
);
  localparam int CW = $clog2(LINE_LENGTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [LINE_LENGTH-1:0] acc, a_in, opr_sr, wrk_sr, res_sr;
  logic [INSTR_FUNCTION_BITS-1:0] op;
  logic [CW-1:0] cnt;
  logic carry, ovf, valid, start_ok, last, inv, arith, b_bit, sum, cout, r_bit;
  for (genvar i = 0; i < LINE_LENGTH; i++) begin : g_bits
    assign a_in[i]  = b_A_DATA_IN[i];
    assign b_ACC[i] = acc[i];
  end
  assign valid     = b_FST == INST_LDA || b_FST == INST_ADD || b_FST == INST_SUB ||
                     b_FST == INST_NEG || b_FST == INST_SHR;
  assign start_ok  = state == IDLE && w_START && valid;
  assign last      = cnt == CW'(LINE_LENGTH - 1);
  assign inv       = op == INST_SUB || op == INST_NEG;
  assign arith     = inv || op == INST_ADD;
  assign b_bit     = opr_sr[0] ^ inv;
  assign sum       = wrk_sr[0] ^ b_bit ^ carry;
  assign cout      = (wrk_sr[0] & b_bit) | (carry & (wrk_sr[0] ^ b_bit));
  assign r_bit     = op == INST_LDA ? opr_sr[0] : op == INST_SHR ? wrk_sr[1] : sum;
  assign w_ACC_NEG = acc[LINE_LENGTH-1];
  assign w_BUSY    = state == RUN;
  assign w_DONE    = state == DONE;
  assign w_OVF     = ovf;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start_ok ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge w_CLK or negedge w_RST_N)
    if (!w_RST_N) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge w_CLK or negedge w_RST_N)
    if (!w_RST_N) begin
      acc    <= '0;
      opr_sr <= '0;
      wrk_sr <= '0;
      res_sr <= '0;
      op     <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else if (start_ok) begin
      opr_sr <= a_in;
      op     <= b_FST;
      wrk_sr <= (w_ACEG || b_FST == INST_NEG) ? '0 : acc;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= b_FST == INST_SUB || b_FST == INST_NEG;
      if (w_ACEG) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end else if (state == RUN) begin
      opr_sr <= opr_sr >> 1;
      wrk_sr <= {wrk_sr[LINE_LENGTH-1], wrk_sr[LINE_LENGTH-1:1]};
      res_sr <= {r_bit, res_sr[LINE_LENGTH-1:1]};
      carry  <= cout;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        acc <= {r_bit, res_sr[LINE_LENGTH-1:1]};
        ovf <= arith & (carry ^ cout);
      end
    end else if (state == IDLE && w_ACEG) begin
      acc <= '0;
      ovf <= 1'b0;
    end
endmodule
